// File: rtl/reg_access_sequencer_pkg.sv
// Shared definitions for the register-file operand sequencer:
// register_file geometry defaults and the 3-bit FSM state encoding.
package reg_access_sequencer_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

endpackage

// File: rtl/reg_access_sequencer_if.sv
// Request/completion channel between decode/control (master) and the
// sequencer (slave). Fields are sampled by the sequencer on accept.
interface reg_access_sequencer_if
  import reg_access_sequencer_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic              start;
  logic              ready;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic              use_b;
  logic              wb_en;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start, rs, rt, rd, use_b, wb_en,
    input  ready, done, result
  );

  modport slave (
    input  start, rs, rt, rd, use_b, wb_en,
    output ready, done, result
  );
endinterface

// File: rtl/reg_access_sequencer.sv
// Operand-fetch / write-back sequencer for a single-port register file.
// One register access per cycle: read rs, optionally read rt, latch the
// external ALU result, optionally write it to rd.
module reg_access_sequencer
  import reg_access_sequencer_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter bit ZERO_REG_RO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_access_sequencer_if.slave req,
  output logic [ADDR_W-1:0]     rf_regsel,
  output logic                  rf_wrreg,
  output logic [DATA_W-1:0]     rf_din,
  input  logic [DATA_W-1:0]     rf_dout,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_result
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic              use_b_q, wb_en_q;
  logic [DATA_W-1:0] result_q;
  logic              done_q;
  logic              suppress;

  // FSM, operand/result registers and the registered done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      use_b_q  <= 1'b0;
      wb_en_q  <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req.start) begin
            rs_q    <= req.rs;
            rt_q    <= req.rt;
            rd_q    <= req.rd;
            use_b_q <= req.use_b;
            wb_en_q <= req.wb_en;
            state   <= S_RD_A;
          end
        end
        S_RD_A: begin
          alu_a <= rf_dout;
          if (use_b_q) begin
            state <= S_RD_B;
          end else begin
            alu_b <= '0;
            state <= S_EXEC;
          end
        end
        S_RD_B: begin
          alu_b <= rf_dout;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= alu_result;
          if (wb_en_q) begin
            state <= S_WB;
          end else begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        S_WB: begin
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register-file port decode; EXEC parks the select on register 0
  always_comb begin
    rf_regsel = '0;
    rf_din    = '0;
    case (state)
      S_RD_A:  rf_regsel = rs_q;
      S_RD_B:  rf_regsel = rt_q;
      S_WB: begin
        rf_regsel = rd_q;
        rf_din    = result_q;
      end
      default: ;
    endcase
  end

  // Write strobe is masked by rst so a reset landing in WB never commits
  assign suppress   = ZERO_REG_RO && (rd_q == '0);
  assign rf_wrreg   = (state == S_WB) && !rst && !suppress;

  assign req.ready  = (state == S_IDLE);
  assign req.done   = done_q;
  assign req.result = result_q;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Bench: two sequencers (ZERO_REG_RO=0 and 1) run in lockstep, each with its
// own behavioural register file, an adder ALU and a backdoor preload mux.
// A per-instance array model predicts operands, result, write-back, the
// select sequence and completion latency.
module tb_reg_access_sequencer;
  import reg_access_sequencer_pkg::*;

  localparam int DW = RF_DATA_W;
  localparam int AW = RF_ADDR_W;
  localparam int NR = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_access_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) rq0 ();
  reg_access_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) rq1 ();

  logic [1:0][AW-1:0] sel;
  logic [1:0]         wr;
  logic [1:0][DW-1:0] din, dout, alu_a, alu_b, alu_res;

  reg_access_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG_RO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req(rq0.slave),
    .rf_regsel(sel[0]), .rf_wrreg(wr[0]), .rf_din(din[0]), .rf_dout(dout[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_result(alu_res[0]));

  reg_access_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG_RO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req(rq1.slave),
    .rf_regsel(sel[1]), .rf_wrreg(wr[1]), .rf_din(din[1]), .rf_dout(dout[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_result(alu_res[1]));

  // register files with backdoor preload priority
  logic [DW-1:0] mem [2][NR];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bd_we) mem[i][bd_addr] <= bd_data;
      else if (wr[i]) mem[i][sel[i]] <= din[i];
    end
  end

  assign dout[0]    = mem[0][sel[0]];
  assign dout[1]    = mem[1][sel[1]];
  assign alu_res[0] = alu_a[0] + alu_b[0];
  assign alu_res[1] = alu_a[1] + alu_b[1];

  // reference model state
  logic [DW-1:0] m [2][NR];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic s, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic ub, input logic wb);
    rq0.start = s; rq0.rs = a; rq0.rt = b; rq0.rd = d; rq0.use_b = ub; rq0.wb_en = wb;
    rq1.start = s; rq1.rs = a; rq1.rt = b; rq1.rd = d; rq1.use_b = ub; rq1.wb_en = wb;
  endtask

  // random request fields, start random: only used while the DUTs are busy
  task automatic garbage();
    logic [31:0] x;
    x = $urandom;
    set_req(x[0], x[1+:AW], x[1+AW+:AW], x[1+2*AW+:AW], x[1+3*AW], x[2+3*AW]);
  endtask

  // called at a negedge with both DUTs idle
  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
    @(negedge clk);
    m[0][addr] = data;
    m[1][addr] = data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("idle_done%0d", i), DW'(i == 0 ? rq0.done : rq1.done), DW'(0));
        check($sformatf("idle_ready%0d", i), DW'(i == 0 ? rq0.ready : rq1.ready), DW'(1));
      end
    end
  endtask

  // Issue one op at a negedge in IDLE; returns at the negedge of the done cycle
  task automatic run_op(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic ub, input logic wb);
    int lat;
    logic [DW-1:0] ea [2];
    logic [DW-1:0] eb [2];
    logic [DW-1:0] er [2];
    logic [AW-1:0] exp_sel [$];
    logic ewr, rdy, dn;
    logic [DW-1:0] res;
    lat = 3 + int'(ub) + int'(wb);
    for (int i = 0; i < 2; i++) begin
      ea[i] = m[i][rs];
      eb[i] = ub ? m[i][rt] : '0;
      er[i] = ea[i] + eb[i];
    end
    exp_sel.push_back(rs);
    if (ub) exp_sel.push_back(rt);
    exp_sel.push_back('0);
    if (wb) exp_sel.push_back(rd);

    check("accept_ready0", DW'(rq0.ready), DW'(1));
    check("accept_ready1", DW'(rq1.ready), DW'(1));
    set_req(1'b1, rs, rt, rd, ub, wb);
    @(posedge clk);
    #1 garbage();
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rdy = (i == 0) ? rq0.ready : rq1.ready;
        dn  = (i == 0) ? rq0.done  : rq1.done;
        res = (i == 0) ? rq0.result : rq1.result;
        if (cyc < lat) begin
          ewr = (cyc == lat - 1) && wb && !(i == 1 && rd == '0);
          check($sformatf("sel%0d_c%0d", i, cyc), DW'(sel[i]), DW'(exp_sel[cyc-1]));
          check($sformatf("wr%0d_c%0d", i, cyc), DW'(wr[i]), DW'(ewr));
          if (ewr) check($sformatf("din%0d", i), din[i], er[i]);
          check($sformatf("busy_ready%0d", i), DW'(rdy), DW'(0));
          check($sformatf("early_done%0d", i), DW'(dn), DW'(0));
        end else begin
          check($sformatf("done%0d", i), DW'(dn), DW'(1));
          check($sformatf("done_ready%0d", i), DW'(rdy), DW'(1));
          check($sformatf("result%0d", i), res, er[i]);
          check($sformatf("alu_a%0d", i), alu_a[i], ea[i]);
          check($sformatf("alu_b%0d", i), alu_b[i], eb[i]);
          check($sformatf("idle_sel%0d", i), DW'(sel[i]), DW'(0));
          check($sformatf("idle_wr%0d", i), DW'(wr[i]), DW'(0));
          if (wb && !(i == 1 && rd == '0)) m[i][rd] = er[i];
          check($sformatf("mem%0d_rd", i), mem[i][rd], m[i][rd]);
        end
      end
      if (cyc < lat) garbage();
      else set_req(1'b0, '0, '0, '0, 1'b0, 1'b0);
    end
  endtask

  // Start a full op and assert rst during its WB cycle
  task automatic reset_in_wb(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                             input logic [AW-1:0] rd);
    set_req(1'b1, rs, rt, rd, 1'b1, 1'b1);
    @(posedge clk);
    #1 set_req(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("wb_sel0", DW'(sel[0]), DW'(rd));
    rst = 1'b1;
    #1;
    check("rst_wr0", DW'(wr[0]), DW'(0));
    check("rst_wr1", DW'(wr[1]), DW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ready%0d", i), DW'(i == 0 ? rq0.ready : rq1.ready), DW'(1));
      check($sformatf("rst_done%0d", i), DW'(i == 0 ? rq0.done : rq1.done), DW'(0));
      check($sformatf("rst_result%0d", i), i == 0 ? rq0.result : rq1.result, DW'(0));
      check($sformatf("rst_alu_a%0d", i), alu_a[i], DW'(0));
      check($sformatf("rst_mem%0d", i), mem[i][rd], m[i][rd]);
    end
    idle(1);
  endtask

  initial begin
    rst   = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    set_req(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("por_ready%0d", i), DW'(i == 0 ? rq0.ready : rq1.ready), DW'(1));
      check($sformatf("por_done%0d", i), DW'(i == 0 ? rq0.done : rq1.done), DW'(0));
      check($sformatf("por_result%0d", i), i == 0 ? rq0.result : rq1.result, DW'(0));
      check($sformatf("por_alu_a%0d", i), alu_a[i], DW'(0));
      check($sformatf("por_alu_b%0d", i), alu_b[i], DW'(0));
      check($sformatf("por_sel%0d", i), DW'(sel[i]), DW'(0));
      check($sformatf("por_wr%0d", i), DW'(wr[i]), DW'(0));
      check($sformatf("por_din%0d", i), din[i], DW'(0));
    end

    for (int r = 0; r < NR; r++) preload(AW'(r), (r == 0) ? '0 : DW'($urandom));
    preload(4'd1, 32'd5);
    preload(4'd2, 32'd7);

    run_op(4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
    check("dir_r3", mem[0][3], 32'd12);
    idle(1);
    run_op(4'd1, 4'd6, 4'd4, 1'b0, 1'b1);
    check("dir_r4", mem[0][4], 32'd5);
    idle(2);
    run_op(4'd1, 4'd2, 4'd5, 1'b1, 1'b0);
    check("dir_nowb_res", rq0.result, 32'd12);
    idle(1);
    run_op(4'd1, 4'd2, 4'd0, 1'b1, 1'b1);
    check("dir_r0_rw", mem[0][0], 32'd12);
    check("dir_r0_ro", mem[1][0], 32'd0);
    idle(1);
    run_op(4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
    run_op(4'd3, 4'd1, 4'd5, 1'b1, 1'b1);
    check("dir_b2b_r5", mem[0][5], 32'd17);
    idle(1);
    reset_in_wb(4'd1, 4'd2, 4'd6);

    for (int k = 0; k < 150; k++) begin
      logic [31:0] x;
      x = $urandom;
      run_op(x[0+:AW], x[AW+:AW], x[2*AW+:AW], x[3*AW], x[3*AW+1]);
      idle(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
